// File: rtl/writeback_pkg.sv
// Shared types and constants for the bexkat1 pipeline: write-class encoding,
// instruction type codes and load-size decoding.
package bexkat1Def;

  typedef enum logic [1:0] {
    RW_NONE = 2'd0,
    RW_RA   = 2'd1,
    RW_SP   = 2'd2,
    RW_RESV = 2'd3
  } reg_write_t;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } size_t;

  localparam logic [3:0] T_LOAD = 4'h7;
  localparam logic [3:0] SP_IDX = 4'd15;

  // op[1:0] selects the load width; the spare code 3 behaves as a full word.
  function automatic size_t op_size(input logic [3:0] op);
    case (op[1:0])
      2'd1:    return SZ_HALF;
      2'd2:    return SZ_BYTE;
      default: return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/wb_align.sv
// Load data extraction: picks a big-endian byte/half lane from the bus word and extends it.
// Purely combinational.
module wb_align
  import bexkat1Def::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  adr_lo,
  input  size_t       size,
  input  logic        sign_ext,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = word[31:24];
    case (adr_lo)
      2'd0: byte_lane = word[31:24];
      2'd1: byte_lane = word[23:16];
      2'd2: byte_lane = word[15:8];
      2'd3: byte_lane = word[7:0];
      default: byte_lane = word[31:24];
    endcase
    half_lane = adr_lo[1] ? word[15:0] : word[31:16];

    data = word;
    case (size)
      SZ_BYTE: data = {{24{sign_ext & byte_lane[7]}}, byte_lane};
      SZ_HALF: data = {{16{sign_ext & half_lane[15]}}, half_lane};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/writeback.sv
// Final pipeline stage: latches mem results (W1), commits to the owned register file (W2),
// serves two bypassed decode read ports and counts retired instructions.
module writeback
  import bexkat1Def::*;
#(
  parameter int NREGS     = 16,
  parameter int INSTRET_W = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     stall_i,
  input  logic [63:0]              ir_i,
  input  logic [31:0]              pc_i,
  input  reg_write_t               reg_write_i,
  input  logic [31:0]              result_i,
  input  logic [1:0]               adr_lo_i,
  input  logic [$clog2(NREGS)-1:0] rd_a_i,
  input  logic [$clog2(NREGS)-1:0] rd_b_i,
  output logic [31:0]              rd_a_o,
  output logic [31:0]              rd_b_o,
  output logic                     fwd_valid_o,
  output logic [$clog2(NREGS)-1:0] fwd_idx_o,
  output logic [31:0]              fwd_data_o,
  output logic [INSTRET_W-1:0]     instret_o
);

  localparam int IDX_W = $clog2(NREGS);

  logic [3:0]       in_type;
  logic [3:0]       in_op;
  logic [IDX_W-1:0] in_ra;
  logic [IDX_W-1:0] in_idx;
  logic [31:0]      aligned;
  logic [31:0]      in_data;

  logic             w1_valid;
  reg_write_t       w1_rw;
  logic [IDX_W-1:0] w1_idx;
  logic [31:0]      w1_data;

  logic [31:0]      regs [NREGS];
  logic [INSTRET_W-1:0] instret;

  assign in_type = ir_i[31:28];
  assign in_op   = ir_i[27:24];
  assign in_ra   = ir_i[20 +: IDX_W];

  // Only the destination and data survive into W1; pc and the remaining ir bits are
  // carried by the mem stage for debug and have no consumer here.
  logic unused_ok;
  assign unused_ok = ^{ir_i[63:32], ir_i[19:0], pc_i};

  wb_align u_align (
    .word     (result_i),
    .adr_lo   (adr_lo_i),
    .size     (op_size(in_op)),
    .sign_ext (in_op[3]),
    .data     (aligned)
  );

  assign in_data = (in_type == T_LOAD) ? aligned : result_i;
  assign in_idx  = (reg_write_i == RW_SP) ? IDX_W'(SP_IDX) : in_ra;

  // W1: a stall only drops valid; the held contents stay visible for forwarding.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      w1_valid <= 1'b0;
      w1_rw    <= RW_NONE;
      w1_idx   <= '0;
      w1_data  <= '0;
    end else if (stall_i) begin
      w1_valid <= 1'b0;
    end else begin
      w1_valid <= 1'b1;
      w1_rw    <= reg_write_i;
      w1_idx   <= in_idx;
      w1_data  <= in_data;
    end
  end

  // W2: commit and retire.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      instret <= '0;
    end else if (w1_valid) begin
      if (w1_rw != RW_NONE) regs[w1_idx] <= w1_data;
      instret <= instret + 1'b1;
    end
  end

  assign fwd_valid_o = w1_valid && (w1_rw != RW_NONE);
  assign fwd_idx_o   = w1_idx;
  assign fwd_data_o  = w1_data;
  assign instret_o   = instret;

  assign rd_a_o = (fwd_valid_o && fwd_idx_o == rd_a_i) ? fwd_data_o : regs[rd_a_i];
  assign rd_b_o = (fwd_valid_o && fwd_idx_o == rd_b_i) ? fwd_data_o : regs[rd_b_i];

endmodule

// File: tb/tb_writeback.sv
// Scoreboard bench for writeback: forwarded writes are queued at drive time and checked
// once they appear in W1; a shadow register file checks both read ports.
module tb_writeback;
  import bexkat1Def::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i;
  logic [63:0] ir_i;
  logic [31:0] pc_i;
  reg_write_t  reg_write_i;
  logic [31:0] result_i;
  logic [1:0]  adr_lo_i;
  logic [3:0]  rd_a_i, rd_b_i;
  logic [31:0] rd_a_o, rd_b_o;
  logic        fwd_valid_o;
  logic [3:0]  fwd_idx_o;
  logic [31:0] fwd_data_o;
  logic [63:0] instret_o;

  writeback #(.NREGS(16), .INSTRET_W(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .ir_i(ir_i), .pc_i(pc_i),
    .reg_write_i(reg_write_i), .result_i(result_i), .adr_lo_i(adr_lo_i),
    .rd_a_i(rd_a_i), .rd_b_i(rd_b_i), .rd_a_o(rd_a_o), .rd_b_o(rd_b_o),
    .fwd_valid_o(fwd_valid_o), .fwd_idx_o(fwd_idx_o), .fwd_data_o(fwd_data_o),
    .instret_o(instret_o)
  );

  always #20 clk_i = ~clk_i;

  typedef struct {
    logic [3:0]  idx;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  logic [31:0] m_regs [16];
  logic        m_w1_vld, m_w1_wr;
  logic [3:0]  m_w1_idx;
  logic [31:0] m_w1_data;
  logic [63:0] m_instret;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_align(input logic [3:0] typ, input logic [3:0] op,
                                            input logic [31:0] w, input logic [1:0] adr);
    logic [31:0] v;
    int sh;
    if (typ != T_LOAD) return w;
    if (op[1:0] == 2'd2) begin
      sh = (3 - int'(adr)) * 8;
      v = (w >> sh) & 32'h0000_00FF;
      if (op[3] && v[7]) v = v | 32'hFFFF_FF00;
    end else if (op[1:0] == 2'd1) begin
      sh = adr[1] ? 0 : 16;
      v = (w >> sh) & 32'h0000_FFFF;
      if (op[3] && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] i);
    if (m_w1_vld && m_w1_wr && m_w1_idx == i) return m_w1_data;
    return m_regs[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_w1_vld = 1'b0; m_w1_wr = 1'b0; m_w1_idx = '0; m_w1_data = '0;
    m_instret = '0;
    exp_q.delete();
  endtask

  // Sweeps all 16 indices on both ports; fits inside one half clock period.
  task automatic check_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_a_i = 4'(i);
      rd_b_i = 4'(15 - i);
      #1;
      chk({tag, "_rd_a"}, {32'h0, rd_a_o}, {32'h0, model_read(4'(i))});
      chk({tag, "_rd_b"}, {32'h0, rd_b_o}, {32'h0, model_read(4'(15 - i))});
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic cycle(input logic stall, input logic [3:0] typ, input logic [3:0] op,
                       input logic [3:0] ra, input logic [1:0] rw,
                       input logic [31:0] res, input logic [1:0] adr);
    exp_t e;
    logic [3:0] idx;
    logic [31:0] d;
    stall_i     = stall;
    ir_i        = {$urandom(), typ, op, ra, 20'($urandom())};
    pc_i        = $urandom();
    reg_write_i = reg_write_t'(rw);
    result_i    = res;
    adr_lo_i    = adr;
    idx = (rw == 2'd2) ? 4'd15 : ra;
    d   = exp_align(typ, op, res, adr);
    if (!stall && rw != 2'd0) begin
      e.idx = idx; e.data = d;
      exp_q.push_back(e);
    end
    @(posedge clk_i);
    if (m_w1_vld) begin
      m_instret = m_instret + 64'd1;
      if (m_w1_wr) m_regs[m_w1_idx] = m_w1_data;
    end
    m_w1_vld = !stall;
    if (!stall) begin
      m_w1_wr = (rw != 2'd0); m_w1_idx = idx; m_w1_data = d;
    end
    #2;
    if (!stall && rw != 2'd0) begin
      chk("q_nonempty", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("fwd_valid", 64'(fwd_valid_o), 64'd1);
        chk("fwd_idx", 64'(fwd_idx_o), 64'(e.idx));
        chk("fwd_data", 64'(fwd_data_o), 64'(e.data));
        rd_a_i = e.idx;
        #1;
        chk("bypass_rd_a", 64'(rd_a_o), 64'(e.data));
      end
    end else begin
      chk("fwd_valid_off", 64'(fwd_valid_o), 64'd0);
    end
    chk("instret", instret_o, m_instret);
    @(negedge clk_i);
  endtask

  task automatic idle();
    cycle(1'b1, 4'h0, 4'h0, 4'h0, 2'd0, 32'h0, 2'd0);
  endtask

  initial begin
    rst_i = 1'b0; stall_i = 1'b1; ir_i = '0; pc_i = '0; reg_write_i = RW_NONE;
    result_i = '0; adr_lo_i = '0; rd_a_i = '0; rd_b_i = '0;
    model_reset();
    #2;
    chk("rst_fwd_valid", 64'(fwd_valid_o), 64'd0);
    chk("rst_fwd_idx", 64'(fwd_idx_o), 64'd0);
    chk("rst_fwd_data", 64'(fwd_data_o), 64'd0);
    chk("rst_instret", instret_o, 64'd0);
    check_regs("rst");
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;

    // ALU write with bypass, then commit
    cycle(1'b0, 4'h0, 4'h0, 4'd3, 2'd1, 32'hDEAD_BEEF, 2'd0);
    check_regs("alu_bypass");
    idle();
    rd_a_i = 4'd3; #1;
    chk("alu_commit_r3", 64'(rd_a_o), 64'h0000_0000_DEAD_BEEF);
    check_regs("alu_commit");

    // Loads: byte unsigned/signed, halves, word, non-load with load-like op
    cycle(1'b0, T_LOAD, 4'h2, 4'd4, 2'd1, 32'h1122_3344, 2'd2);
    cycle(1'b0, T_LOAD, 4'hA, 4'd6, 2'd1, 32'h1122_8300, 2'd2);
    cycle(1'b0, T_LOAD, 4'h9, 4'd8, 2'd1, 32'h8001_1234, 2'd0);
    cycle(1'b0, T_LOAD, 4'h1, 4'd9, 2'd1, 32'h8001_F234, 2'd2);
    cycle(1'b0, T_LOAD, 4'hA, 4'd10, 2'd1, 32'h7F00_0000, 2'd0);
    cycle(1'b0, T_LOAD, 4'h3, 4'd11, 2'd3, 32'hA5A5_0F0F, 2'd1);
    cycle(1'b0, 4'h0, 4'hA, 4'd12, 2'd1, 32'h1122_8300, 2'd2);
    idle();
    rd_a_i = 4'd4; rd_b_i = 4'd6; #1;
    chk("ldb_zext", 64'(rd_a_o), 64'h0000_0000_0000_0033);
    chk("ldb_sext", 64'(rd_b_o), 64'h0000_0000_FFFF_FF83);
    rd_a_i = 4'd8; #1;
    chk("ldh_sext", 64'(rd_a_o), 64'h0000_0000_FFFF_8001);
    check_regs("loads");

    // Stall with garbage inputs: nothing commits, instret holds
    for (int k = 0; k < 3; k++)
      cycle(1'b1, 4'($urandom()), 4'($urandom()), 4'($urandom()), 2'($urandom()),
            $urandom(), 2'($urandom()));
    check_regs("stall");

    // Stack-pointer class and no-write class
    cycle(1'b0, 4'h0, 4'h0, 4'd2, 2'd2, 32'h0000_1000, 2'd0);
    cycle(1'b0, 4'h0, 4'h0, 4'd7, 2'd0, 32'h5555_5555, 2'd0);
    idle();
    rd_a_i = 4'd15; rd_b_i = 4'd2; #1;
    chk("sp_r15", 64'(rd_a_o), 64'h0000_0000_0000_1000);
    chk("sp_r2", 64'(rd_b_o), 64'd0);
    check_regs("sp_none");

    // Back-to-back writes to the same index
    cycle(1'b0, 4'h0, 4'h0, 4'd5, 2'd1, 32'd1, 2'd0);
    rd_a_i = 4'd5; #1;
    chk("b2b_first", 64'(rd_a_o), 64'd1);
    cycle(1'b0, 4'h0, 4'h0, 4'd5, 2'd1, 32'd2, 2'd0);
    rd_a_i = 4'd5; #1;
    chk("b2b_second", 64'(rd_a_o), 64'd2);
    idle();
    rd_a_i = 4'd5; rd_b_i = 4'd5; #1;
    chk("b2b_final_a", 64'(rd_a_o), 64'd2);
    chk("b2b_final_b", 64'(rd_b_o), 64'd2);

    // Random mix, r0 included as an ordinary register
    for (int k = 0; k < 40; k++)
      cycle(1'($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1) ? T_LOAD : 4'h0,
            4'($urandom()), 4'($urandom()), 2'($urandom()), $urandom(), 2'($urandom()));
    check_regs("random");

    // Reset while a write is pending in W1
    cycle(1'b0, 4'h0, 4'h0, 4'd7, 2'd1, 32'hCAFE_F00D, 2'd0);
    stall_i = 1'b1;
    rst_i = 1'b0;
    #1;
    model_reset();
    chk("midrst_fwd_valid", 64'(fwd_valid_o), 64'd0);
    chk("midrst_instret", instret_o, 64'd0);
    check_regs("midrst");
    @(negedge clk_i);
    rst_i = 1'b1;
    idle();
    check_regs("post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
